// File: rtl/pci_pkg.sv
// Shared PCI definitions: arbiter state encoding, active-low signal levels
// and the bus command codes that the target also decodes.
package pci_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PARK  = 3'd1,
        GRANT = 3'd2,
        BUSY  = 3'd3,
        TURN  = 3'd4
    } arb_state_t;

    // All PCI handshake lines in this slice are active-low.
    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    typedef enum logic [3:0] {
        READ  = 4'b0010,
        WRITE = 4'b0011
    } pci_cmd_t;

endpackage : pci_pkg

// File: rtl/pci_bus_arbiter_rr_picker.sv
// Combinational round-robin search: the first active-low request found after
// last_winner (wrapping modulo N) wins.
module rr_picker
    import pci_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_winner,
    output logic [$clog2(N)-1:0] winner,
    output logic                 any_req
);

    localparam int W = $clog2(N);

    always_comb begin
        logic [W-1:0] cand;
        // NOTE: every output gets a default before the search loop, otherwise
        // the paths where no request matches would infer latches.
        winner  = last_winner;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(last_winner) + k) % N);
            if (!any_req && req[cand] == ASSERTED) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

endmodule : rr_picker

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin grants with parking, start timeout and
// pre-arbitration while the current owner's transaction is still running.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int PARK_MASTER   = 0,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic                           frame,
    input  logic                           irdy,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] bus_owner,
    output logic                           bus_busy
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int TW = $clog2(START_TIMEOUT);
    localparam logic [OW-1:0] PARK_IDX  = OW'(PARK_MASTER);
    localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_MASTERS - 1);
    localparam logic [TW-1:0] TIMER_END = TW'(START_TIMEOUT - 1);

    arb_state_t             state, state_n;
    logic [NUM_MASTERS-1:0] gnt_n;
    logic [OW-1:0]          owner_n, last_winner, last_n, winner;
    logic [TW-1:0]          timer, timer_n;
    logic                   any_req, other_req, bus_idle;

    function automatic logic [NUM_MASTERS-1:0] grant_to(input logic [OW-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v      = {NUM_MASTERS{DEASSERTED}};
        v[idx] = ASSERTED;
        return v;
    endfunction

    rr_picker #(.N(NUM_MASTERS)) u_picker (
        .req         (req),
        .last_winner (last_winner),
        .winner      (winner),
        .any_req     (any_req)
    );

    assign bus_idle  = (frame == DEASSERTED) && (irdy == DEASSERTED);
    // Requests from anyone but the master currently holding the grant.
    assign other_req = |(~req & grant_to(bus_owner));

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = bus_owner;
        last_n  = last_winner;
        timer_n = timer;
        case (state)
            IDLE, TURN: begin
                if (any_req) begin
                    gnt_n   = grant_to(winner);
                    owner_n = winner;
                    timer_n = '0;
                    state_n = GRANT;
                end else begin
                    gnt_n   = grant_to(PARK_IDX);
                    owner_n = PARK_IDX;
                    state_n = PARK;
                end
            end
            PARK: begin
                if (frame == ASSERTED) begin
                    state_n = BUSY;
                end else if (other_req) begin
                    gnt_n   = '1;
                    state_n = TURN;
                end else if (req[PARK_IDX] == ASSERTED) begin
                    timer_n = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (frame == ASSERTED) begin
                    last_n  = bus_owner;
                    state_n = BUSY;
                end else if (req[bus_owner] == DEASSERTED) begin
                    gnt_n   = '1;
                    state_n = TURN;
                end else if (timer == TIMER_END) begin
                    // A master that never started drops to lowest priority.
                    gnt_n   = '1;
                    last_n  = bus_owner;
                    state_n = TURN;
                end else if (timer != '1) begin
                    timer_n = timer + 1'b1;
                end
            end
            BUSY: begin
                if (bus_idle) begin
                    gnt_n   = '1;
                    state_n = TURN;
                end else if (other_req) begin
                    gnt_n = '1;
                end
            end
            default: begin
                gnt_n   = '1;
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '1;
            bus_owner   <= PARK_IDX;
            bus_busy    <= 1'b0;
            last_winner <= LAST_IDX;
            timer       <= '0;
        end else begin
            state       <= state_n;
            gnt         <= gnt_n;
            bus_owner   <= owner_n;
            bus_busy    <= !bus_idle;
            last_winner <= last_n;
            timer       <= timer_n;
        end
    end

endmodule : pci_bus_arbiter

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: per-cycle stimulus rows carry the
// expected registered outputs, which are queued and compared after each edge.
module tb_pci_bus_arbiter;

    typedef struct packed {
        logic [3:0] req;
        logic       frame;
        logic       irdy;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
    } row_t;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b1111;
    logic       frame = 1'b1;
    logic       irdy = 1'b1;
    logic [3:0] gnt;
    logic [1:0] bus_owner;
    logic       bus_busy;

    int   checks = 0;
    int   failures = 0;
    row_t stim_q[$];
    obs_t exp_q[$];

    pci_bus_arbiter #(
        .NUM_MASTERS   (4),
        .PARK_MASTER   (0),
        .START_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .frame     (frame),
        .irdy      (irdy),
        .gnt       (gnt),
        .bus_owner (bus_owner),
        .bus_busy  (bus_busy)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [3:0] r, input logic f, input logic i,
                       input logic [3:0] g, input logic [1:0] o, input logic b);
        stim_q.push_back({r, f, i, g, o, b});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b1111;
        frame = 1'b1;
        irdy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        row_t row;
        obs_t want;
        int   n = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({gnt, bus_owner, bus_busy} !== 7'b1111_00_0) begin
            failures++;
            $display("FAIL reset_async: gnt=%b owner=%0d busy=%b, want gnt=1111 owner=0 busy=0",
                     gnt, bus_owner, bus_busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        add(4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);
        add(4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);
        while (stim_q.size() > 0) begin
            row = stim_q.pop_front();
            req = row.req; frame = row.frame; irdy = row.irdy;
            exp_q.push_back({row.gnt, row.owner, row.busy});
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if ({gnt, bus_owner, bus_busy} !== want) begin
                failures++;
                $display("FAIL reset[%0d]: gnt=%b owner=%0d busy=%b, want gnt=%b owner=%0d busy=%b",
                         n, gnt, bus_owner, bus_busy, want.gnt, want.owner, want.busy);
            end
            n++;
        end
    endtask

    task automatic test_park();
        row_t row;
        obs_t want;
        int   n = 0;
        do_reset();
        add(4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);  // park on master 0
        add(4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);
        add(4'b1011, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0);  // turnaround
        add(4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);  // master 2 granted
        add(4'b1111, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1);
        add(4'b1111, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1);
        add(4'b1111, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0);  // idle -> turnaround
        add(4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);  // parked again
        add(4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);  // park master requests
        add(4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0);  // withdrawn
        add(4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);
        while (stim_q.size() > 0) begin
            row = stim_q.pop_front();
            req = row.req; frame = row.frame; irdy = row.irdy;
            exp_q.push_back({row.gnt, row.owner, row.busy});
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if ({gnt, bus_owner, bus_busy} !== want) begin
                failures++;
                $display("FAIL park[%0d]: gnt=%b owner=%0d busy=%b, want gnt=%b owner=%0d busy=%b",
                         n, gnt, bus_owner, bus_busy, want.gnt, want.owner, want.busy);
            end
            n++;
        end
    endtask

    task automatic test_round_robin();
        row_t       row;
        obs_t       want;
        logic [3:0] g;
        int         n = 0;
        do_reset();
        for (int m = 0; m < 4; m++) begin
            g = ~(4'b0001 << m);
            add(4'b0000, 1'b1, 1'b1, g, 2'(m), 1'b0);
            add(4'b0000, 1'b0, 1'b0, g, 2'(m), 1'b1);
            add(4'b0000, 1'b1, 1'b1, 4'b1111, 2'(m), 1'b0);
        end
        add(4'b0000, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);
        while (stim_q.size() > 0) begin
            row = stim_q.pop_front();
            req = row.req; frame = row.frame; irdy = row.irdy;
            exp_q.push_back({row.gnt, row.owner, row.busy});
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if ({gnt, bus_owner, bus_busy} !== want) begin
                failures++;
                $display("FAIL round_robin[%0d]: gnt=%b owner=%0d busy=%b, want gnt=%b owner=%0d busy=%b",
                         n, gnt, bus_owner, bus_busy, want.gnt, want.owner, want.busy);
            end
            n++;
        end
    endtask

    // race=0: master 1 never starts and times out; race=1: frame falls on the
    // timeout edge, so the transaction wins.
    task automatic test_timeout(input bit race);
        row_t row;
        obs_t want;
        int   n = 0;
        do_reset();
        if (!race) begin
            for (int k = 0; k < 16; k++) add(4'b1001, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
            add(4'b1001, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0);
            add(4'b1001, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);
        end else begin
            for (int k = 0; k < 16; k++) add(4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
            add(4'b1101, 1'b0, 1'b0, 4'b1101, 2'd1, 1'b1);
            add(4'b1101, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0);
            add(4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
        end
        while (stim_q.size() > 0) begin
            row = stim_q.pop_front();
            req = row.req; frame = row.frame; irdy = row.irdy;
            exp_q.push_back({row.gnt, row.owner, row.busy});
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if ({gnt, bus_owner, bus_busy} !== want) begin
                failures++;
                $display("FAIL timeout%s[%0d]: gnt=%b owner=%0d busy=%b, want gnt=%b owner=%0d busy=%b",
                         race ? "_race" : "", n, gnt, bus_owner, bus_busy,
                         want.gnt, want.owner, want.busy);
            end
            n++;
        end
    endtask

    task automatic test_preempt();
        row_t row;
        obs_t want;
        int   n = 0;
        do_reset();
        add(4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);  // master 0 granted
        add(4'b1110, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1);  // transaction starts
        add(4'b0110, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b1);  // master 3 asks: gnt removed
        add(4'b0110, 1'b1, 1'b0, 4'b1111, 2'd0, 1'b1);  // irdy still low: busy
        add(4'b0110, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0);  // turnaround
        add(4'b0110, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);  // master 3 beats master 0
        while (stim_q.size() > 0) begin
            row = stim_q.pop_front();
            req = row.req; frame = row.frame; irdy = row.irdy;
            exp_q.push_back({row.gnt, row.owner, row.busy});
            @(posedge clk); @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if ({gnt, bus_owner, bus_busy} !== want) begin
                failures++;
                $display("FAIL preempt[%0d]: gnt=%b owner=%0d busy=%b, want gnt=%b owner=%0d busy=%b",
                         n, gnt, bus_owner, bus_busy, want.gnt, want.owner, want.busy);
            end
            n++;
        end
    endtask

    task automatic test_reset_busy();
        row_t row;
        obs_t want;
        int   n = 0;
        do_reset();
        add(4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0);
        add(4'b1111, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1);  // parked master goes busy
        for (int phase = 0; phase < 2; phase++) begin
            while (stim_q.size() > 0) begin
                row = stim_q.pop_front();
                req = row.req; frame = row.frame; irdy = row.irdy;
                exp_q.push_back({row.gnt, row.owner, row.busy});
                @(posedge clk); @(negedge clk);
                want = exp_q.pop_front();
                checks++;
                if ({gnt, bus_owner, bus_busy} !== want) begin
                    failures++;
                    $display("FAIL reset_busy[%0d]: gnt=%b owner=%0d busy=%b, want gnt=%b owner=%0d busy=%b",
                             n, gnt, bus_owner, bus_busy, want.gnt, want.owner, want.busy);
                end
                n++;
            end
            if (phase == 0) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({gnt, bus_owner, bus_busy} !== 7'b1111_00_0) begin
                    failures++;
                    $display("FAIL reset_busy_async: gnt=%b owner=%0d busy=%b, want gnt=1111 owner=0 busy=0",
                             gnt, bus_owner, bus_busy);
                end
                @(negedge clk);
                rst = 1'b0;
                add(4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);  // straight from IDLE
                add(4'b1011, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_park();
        test_round_robin();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_preempt();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pci_bus_arbiter

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central PCI-style bus arbiter that shares the frame/irdy/ad bus between NUM_MASTERS initiators in front of the PCI target.
- Takes active-low per-master request lines and drives active-low per-master grants, using fair round-robin priority.
- Watches frame/irdy to know when a transaction is in progress, so it hands ownership over only at legal points.
- Parks the bus on a default master when nobody requests, and revokes grants from masters that never start.

Parameters:
- NUM_MASTERS, 4, number of requesting initiators (2..8).
- PARK_MASTER, 0, index granted when no request is pending.
- START_TIMEOUT, 16, clocks a granted master may wait before frame must fall.

Ports:
- clk  input  1  bus clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NUM_MASTERS  active-low request, bit i = master i.
- frame  input  1  active-low bus frame, as driven by current master.
- irdy  input  1  active-low initiator ready.
- gnt  output  NUM_MASTERS  active-low grant; at most one bit low at any time.
- bus_owner  output  clog2(NUM_MASTERS)  index of master holding/last holding grant.
- bus_busy  output  1  high while frame==0 or irdy==0 (registered).

Behaviour:
- Reset (rst=1, async): gnt=all ones, bus_owner=PARK_MASTER, bus_busy=0, state=IDLE, last_winner=NUM_MASTERS-1, timer=0. All outputs are registered.
- Bus idle means frame==1 && irdy==1, sampled at posedge.
- Winner selection: first master with req[i]==0, searching from last_winner+1 modulo NUM_MASTERS.
- States and transitions:
  - IDLE:
    - Any req low: gnt[winner]=0, bus_owner=winner, timer=0, go GRANT.
    - Otherwise: gnt[PARK_MASTER]=0, go PARK.
  - PARK:
    - frame==0: go BUSY.
    - Otherwise, req from a non-park master: gnt=all ones, go TURN.
    - Otherwise, req[PARK_MASTER]==0: go GRANT (gnt unchanged, timer=0).
  - GRANT:
    - frame==0: last_winner=bus_owner, go BUSY.
    - Otherwise, req[bus_owner]==1 (request withdrawn): gnt=all ones, go TURN.
    - Otherwise, timer==START_TIMEOUT-1: gnt=all ones, last_winner=bus_owner, go TURN.
    - Otherwise: timer+1.
  - BUSY:
    - Any other master requests: deassert gnt[bus_owner] at next edge (pre-arbitration). The current transaction continues; the arbiter never forces frame.
    - Bus idle sampled: gnt=all ones, go TURN.
  - TURN: exactly one cycle with gnt=all ones, then evaluate as in IDLE. This guarantees one dead cycle between grants to different masters.
- Latency:
  - From IDLE, req sampled low at edge k gives gnt low after edge k.
  - From PARK to another master: 2 edges (via TURN).
- Simultaneous events:
  - frame falling in PARK/GRANT on the same edge a timeout or other request occurs: BUSY wins.
  - Multiple requests: round robin only, no fixed priority.
- Timer is clog2(START_TIMEOUT) bits and saturates; it is cleared on entering GRANT.
- A master that timed out holds last_winner, so it drops to lowest priority.
- Reset mid-BUSY: gnt=all ones immediately, without waiting for clk. The bus transaction is abandoned by the masters.
- Illegal/unused state encodings recover to IDLE.

Decomposition:
- Shared package pci_pkg:
  - Arbiter state enum (IDLE, PARK, GRANT, BUSY, TURN).
  - Active-low ASSERTED=0/DEASSERTED=1 constants.
  - Bus command codes READ=4'b0010, WRITE=4'b0011 (shared with the target).
- One sub-module, rr_picker: combinational round-robin winner from req and last_winner; outputs winner index and any_req.

Test Plan:
- Reset 3 cycles then release, req=4'b1111 → after first edge gnt=4'b1110 (park master 0), bus_owner=0.
- Parked on 0, req=4'b1011 → next edge gnt=4'b1111, following edge gnt=4'b1011. Drive frame=0 for 2 cycles then frame=irdy=1 → TURN one cycle, then gnt=4'b1110.
- From reset, req=4'b0000 held; each master does a 1-cycle transaction when granted → grant order 0,1,2,3,0, with one all-ones cycle between each.
- req=4'b1101 (master 1) granted, frame held 1 → gnt=4'b1101 for exactly 16 cycles, then 4'b1111. With req[2] also low, master 2 is granted next.
- Master 0 BUSY (frame=0), master 3 asserts req → gnt[0] goes 1 on next edge while frame stays 0. After bus idle: TURN, then gnt=4'b0111.
- Assert rst mid-BUSY, between clock edges → gnt=4'b1111 and bus_busy=0 before the next posedge; after release the arbiter resumes from IDLE.
